clause_evaluation_sequencer: RTL and testbench

// Downstream controller for the one-clause checker. Steps a clause index through every clause of
// the formula and drives the checker's enable. The clause memory is addressed by
// out_clause_index and feeds the checker's coefficients. The block collects each clause's

---
 rtl/clause_solver_pkg.sv | 26 ++
 rtl/clause_evaluation_sequencer.sv | 164 ++++++++++++++++
 tb/tb_clause_evaluation_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/clause_solver_pkg.sv
// Shared definitions for the clause evaluation path: FSM encodings, sizing helpers and
// a saturating counter step.
package clause_solver_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_ISSUE   = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

   // Clause capacity for a given index width.
   function automatic int clause_capacity(input int idx_w);
      return 1 << idx_w;
   endfunction

   // Clause counts run 0..NC inclusive, so they need one bit more than the index.
   function automatic int clause_count_width(input int idx_w);
      return idx_w + 1;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      return (value >= max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/clause_evaluation_sequencer.sv
// Steps the one-clause checker through every clause of the formula and gathers the
// per-clause results into a bitmap, an unsatisfied count and an all-satisfied flag.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for in_start; results of the last run are held
// ST_ISSUE   | enable high for one cycle, checker registers its result
// ST_CAPTURE | sample ready/satisfied, advance index or finish
// ST_DONE    | one-cycle done pulse, results valid
module clause_evaluation_sequencer
   import clause_solver_pkg::*;
#(
   parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
   parameter bit EARLY_EXIT                         = 1'b0
) (
   input  logic                                        in_clk,
   input  logic                                        in_reset_n,
   input  logic                                        in_start,
   input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_number_of_clauses,
   output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
   output logic                                        out_checker_enable,
   input  logic                                        in_checker_ready,
   input  logic                                        in_clause_is_satisfied,
   output logic                                        out_busy,
   output logic                                        out_done,
   output logic [(1<<MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] out_satisfied_bitmap,
   output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_unsatisfied_count,
   output logic                                        out_all_satisfied,
   output logic                                        out_error
);

   localparam int IDX = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
   localparam int NC  = clause_capacity(IDX);
   localparam int CW  = clause_count_width(IDX);

   localparam logic [CW-1:0] NC_V     = CW'(NC);
   localparam logic [CW-1:0] CNT_MAX  = CW'((1 << CW) - 1);

   state_t          state_q, state_d;
   logic [IDX-1:0]  idx_q, idx_d;
   logic [CW-1:0]   n_q, n_d;
   logic [CW-1:0]   n_clamp;
   logic            en_q, en_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [NC-1:0]   bitmap_q, bitmap_d;
   logic [CW-1:0]   count_q, count_d;
   logic            all_sat_q, all_sat_d;
   logic            error_q, error_d;
   logic            last_clause;

   assign n_clamp     = (in_number_of_clauses > NC_V) ? NC_V : in_number_of_clauses;
   assign last_clause = ({1'b0, idx_q} == (n_q - CW'(1)));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      en_d      = en_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bitmap_d  = bitmap_q;
      count_d   = count_q;
      all_sat_d = all_sat_q;
      error_d   = error_q;

      case (state_q)
         ST_IDLE: begin
            if (in_start) begin
               n_d       = n_clamp;
               bitmap_d  = '0;
               count_d   = '0;
               error_d   = 1'b0;
               idx_d     = '0;
               all_sat_d = 1'b0;
               if (n_clamp == '0) begin
                  // An empty formula is trivially satisfied and never touches the checker.
                  all_sat_d = 1'b1;
                  done_d    = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  en_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            en_d    = 1'b0;
            state_d = ST_CAPTURE;
         end

         ST_CAPTURE: begin
            if (!in_checker_ready) begin
               error_d   = 1'b1;
               all_sat_d = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               bitmap_d[idx_q] = in_clause_is_satisfied;
               if (!in_clause_is_satisfied) begin
                  count_d = CW'(sat_inc(32'(count_q), 32'(CNT_MAX)));
               end
               if (last_clause || (!in_clause_is_satisfied && EARLY_EXIT)) begin
                  all_sat_d = (count_d == '0) && !error_q;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  idx_d   = idx_q + IDX'(1);
                  en_d    = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         n_q       <= '0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bitmap_q  <= '0;
         count_q   <= '0;
         all_sat_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bitmap_q  <= bitmap_d;
         count_q   <= count_d;
         all_sat_q <= all_sat_d;
         error_q   <= error_d;
      end
   end

   assign out_clause_index      = idx_q;
   assign out_checker_enable    = en_q;
   assign out_busy              = busy_q;
   assign out_done              = done_q;
   assign out_satisfied_bitmap  = bitmap_q;
   assign out_unsatisfied_count = count_q;
   assign out_all_satisfied     = all_sat_q;
   assign out_error             = error_q;

endmodule

// File: tb/tb_clause_evaluation_sequencer.sv
// Directed bench for clause_evaluation_sequencer: one instance runs to completion, a
// second with EARLY_EXIT=1 shares the stimulus; a small checker model answers both.
module tb_clause_evaluation_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [3:0] nclauses = 4'd0;

   logic [1:0] rdy;
   logic [1:0] sat;
   logic [1:0] en, busy, done, alls, err;
   logic [2:0] idx [2];
   logic [7:0] bm  [2];
   logic [3:0] cnt [2];

   logic [7:0] pattern = 8'hFF;
   int         stall_idx = 99;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   clause_evaluation_sequencer #(
      .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(3),
      .EARLY_EXIT(1'b0)
   ) u_dut (
      .in_clk                (clk),
      .in_reset_n            (rst_n),
      .in_start              (start),
      .in_number_of_clauses  (nclauses),
      .out_clause_index      (idx[0]),
      .out_checker_enable    (en[0]),
      .in_checker_ready      (rdy[0]),
      .in_clause_is_satisfied(sat[0]),
      .out_busy              (busy[0]),
      .out_done              (done[0]),
      .out_satisfied_bitmap  (bm[0]),
      .out_unsatisfied_count (cnt[0]),
      .out_all_satisfied     (alls[0]),
      .out_error             (err[0])
   );

   clause_evaluation_sequencer #(
      .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(3),
      .EARLY_EXIT(1'b1)
   ) u_dut_ee (
      .in_clk                (clk),
      .in_reset_n            (rst_n),
      .in_start              (start),
      .in_number_of_clauses  (nclauses),
      .out_clause_index      (idx[1]),
      .out_checker_enable    (en[1]),
      .in_checker_ready      (rdy[1]),
      .in_clause_is_satisfied(sat[1]),
      .out_busy              (busy[1]),
      .out_done              (done[1]),
      .out_satisfied_bitmap  (bm[1]),
      .out_unsatisfied_count (cnt[1]),
      .out_all_satisfied     (alls[1]),
      .out_error             (err[1])
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Checker model: result appears after the enable edge and holds until the next enable.
   initial begin
      rdy = 2'b00;
      sat = 2'b00;
      forever begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            if (en[s]) begin
               rdy[s] = (int'(idx[s]) != stall_idx);
               sat[s] = pattern[idx[s]];
            end
         end
      end
   end

   // Start at edge 0, then report the cycle in which done is seen and the enable cycles.
   task automatic run(input int sel, input logic [3:0] n, input int extra_at,
                      output int done_cyc, output logic [63:0] en_mask, output logic busy1);
      @(negedge clk);
      nclauses = n;
      start    = 1'b1;
      @(negedge clk);
      done_cyc = -1;
      en_mask  = '0;
      busy1    = busy[sel];
      for (int c = 1; c <= 60; c++) begin
         if (c > 1) @(negedge clk);
         start = 1'b0;
         if (en[sel]) en_mask[c] = 1'b1;
         if (done[sel]) begin
            done_cyc = c;
            break;
         end
         if (c == extra_at) begin
            start    = 1'b1;
            nclauses = 4'd1;
         end
      end
      start = 1'b0;
   endtask

   task automatic settle();
      repeat (20) @(negedge clk);
   endtask

   int          dc;
   logic [63:0] em;
   logic        b1;
   logic        seen_done;

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check_val("rst_index",  32'(idx[0]), 32'd0);
      check_val("rst_bitmap", 32'(bm[0]),  32'd0);
      check_val("rst_outs",   32'({en[0], busy[0], done[0], alls[0], err[0], cnt[0]}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: n=5 all satisfied, with a start while busy that must be dropped
      pattern = 8'hFF; stall_idx = 99;
      run(0, 4'd5, 4, dc, em, b1);
      check_val("t1_done_cycle", 32'(dc), 32'd11);
      check_val("t1_enable_cycles", em[31:0], 32'h0000_02AA);
      check_val("t1_busy_c1", 32'(b1), 32'd1);
      check_val("t1_busy_done", 32'(busy[0]), 32'd0);
      check_val("t1_bitmap", 32'(bm[0]), 32'h1F);
      check_val("t1_count", 32'(cnt[0]), 32'd0);
      check_val("t1_all_sat", 32'(alls[0]), 32'd1);
      settle();

      // 2: n=8, clauses 2 and 6 unsatisfied
      pattern = 8'hBB;
      run(0, 4'd8, 0, dc, em, b1);
      check_val("t2_done_cycle", 32'(dc), 32'd17);
      check_val("t2_bitmap", 32'(bm[0]), 32'hBB);
      check_val("t2_count", 32'(cnt[0]), 32'd2);
      check_val("t2_all_sat", 32'(alls[0]), 32'd0);
      settle();

      // 3: early exit at clause 3
      pattern = 8'hF7;
      run(1, 4'd8, 0, dc, em, b1);
      check_val("t3_done_cycle", 32'(dc), 32'd9);
      check_val("t3_bitmap", 32'(bm[1]), 32'h07);
      check_val("t3_count", 32'(cnt[1]), 32'd1);
      check_val("t3_index", 32'(idx[1]), 32'd3);
      check_val("t3_all_sat", 32'(alls[1]), 32'd0);
      settle();
      check_val("t3_full_bitmap", 32'(bm[0]), 32'hF7);

      // 4: empty formula, then a clamped oversized request
      pattern = 8'hFF;
      run(0, 4'd0, 0, dc, em, b1);
      check_val("t4_n0_done_cycle", 32'(dc), 32'd1);
      check_val("t4_n0_enables", em[31:0], 32'd0);
      check_val("t4_n0_busy", 32'(b1), 32'd0);
      check_val("t4_n0_all_sat", 32'(alls[0]), 32'd1);
      check_val("t4_n0_bitmap", 32'(bm[0]), 32'd0);
      settle();
      run(0, 4'd12, 0, dc, em, b1);
      check_val("t4_n12_done_cycle", 32'(dc), 32'd17);
      check_val("t4_n12_bitmap", 32'(bm[0]), 32'hFF);
      check_val("t4_n12_index", 32'(idx[0]), 32'd7);
      check_val("t4_n12_all_sat", 32'(alls[0]), 32'd1);
      settle();

      // 5: checker never answers on clause 1
      stall_idx = 1;
      run(0, 4'd4, 0, dc, em, b1);
      check_val("t5_done_cycle", 32'(dc), 32'd5);
      check_val("t5_error", 32'(err[0]), 32'd1);
      check_val("t5_all_sat", 32'(alls[0]), 32'd0);
      check_val("t5_bitmap", 32'(bm[0]), 32'h01);
      settle();
      stall_idx = 99;
      run(0, 4'd2, 0, dc, em, b1);
      check_val("t5_rerun_done", 32'(dc), 32'd5);
      check_val("t5_rerun_error", 32'(err[0]), 32'd0);
      check_val("t5_rerun_all_sat", 32'(alls[0]), 32'd1);
      settle();

      // 6: reset during CAPTURE of clause 4 (cycle 10)
      @(negedge clk);
      nclauses = 4'd8;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check_val("t6_pre_index", 32'(idx[0]), 32'd4);
      check_val("t6_pre_enable", 32'(en[0]), 32'd0);
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_index", 32'(idx[0]), 32'd0);
      check_val("t6_rst_bitmap", 32'(bm[0]), 32'd0);
      check_val("t6_rst_outs", 32'({en[0], busy[0], done[0], alls[0], err[0], cnt[0]}), 32'd0);
      seen_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 2) rst_n = 1'b1;
         if (done[0]) seen_done = 1'b1;
      end
      check_val("t6_no_done", 32'(seen_done), 32'd0);
      run(0, 4'd3, 0, dc, em, b1);
      check_val("t6_after_done", 32'(dc), 32'd7);
      check_val("t6_after_bitmap", 32'(bm[0]), 32'h07);
      check_val("t6_after_all_sat", 32'(alls[0]), 32'd1);
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
